// File: rtl/lsu_rmw.sv
// lsu_rmw: byte/half/word load-store sequencer over a word-only RAM, with read-modify-write for sub-word stores, fault checks and a valid/ready core interface
//   clk, rst_n                        clock, asynchronous active-low reset
//   reqValid/reqReady, reqAddress,
//   reqIsStore, reqSize, reqSigned,
//   reqWData                          request from the core, taken in IDLE
//   rspValid/rspReady, rspRData,
//   rspFault                          response, held in DONE until consumed
//   memAddress, memIsStore, memWData,
//   memRData                          word-wide RAM port with combinational read
module lsu_rmw #(
  parameter int MEM_BYTES = 131072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqAddress,
  input  logic        reqIsStore,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqWData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspRData,
  output logic        rspFault,
  output logic [31:0] memAddress,
  output logic        memIsStore,
  output logic [31:0] memWData,
  input  logic [31:0] memRData
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      state;
  logic [31:0] addr, wdata, old, rdata;
  logic [1:0]  size;
  logic        sgn, store, fault;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] ext, mask, merged;
  logic        bad;
  // word accesses are aligned, so the half-lane shift is 0 for them too
  assign sh     = size == 2'd0 ? {addr[1:0], 3'b000} : {addr[1], 4'b0000};
  assign lane   = 16'(memRData >> sh);
  assign ext    = size == 2'd0 ? {{24{sgn & lane[7]}}, lane[7:0]} :
                  size == 2'd1 ? {{16{sgn & lane[15]}}, lane} : memRData;
  assign mask   = size == 2'd0 ? 32'h0000_00ff << sh :
                  size == 2'd1 ? 32'h0000_ffff << sh : 32'hffff_ffff;
  assign merged = (old & ~mask) | ((wdata << sh) & mask);
  // range check is done in 33 bits so addresses near 2^32 cannot wrap into range
  assign bad    = reqSize == 2'd3 || (reqSize == 2'd1 && reqAddress[0]) ||
                  (reqSize == 2'd2 && |reqAddress[1:0]) ||
                  ({1'b0, reqAddress} + (33'd1 << reqSize) > 33'(MEM_BYTES));
  assign reqReady   = rst_n && state == IDLE;
  assign rspValid   = state == DONE;
  assign rspRData   = state == DONE ? rdata : '0;
  assign rspFault   = state == DONE && fault;
  assign memIsStore = state == WRITE;
  assign memAddress = (state == READ || state == WRITE) ? {addr[31:2], 2'b00} : '0;
  assign memWData   = state == WRITE ? merged : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      wdata <= '0;
      old   <= '0;
      rdata <= '0;
      size  <= '0;
      sgn   <= 1'b0;
      store <= 1'b0;
      fault <= 1'b0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          addr  <= reqAddress;
          size  <= reqSize;
          sgn   <= reqSigned;
          store <= reqIsStore;
          wdata <= reqWData;
          fault <= bad;
          rdata <= '0;
          state <= bad ? DONE : (reqIsStore && reqSize == 2'd2) ? WRITE : READ;
        end
        READ: begin
          old   <= memRData;
          rdata <= store ? '0 : ext;
          state <= store ? WRITE : DONE;
        end
        WRITE: state <= DONE;
        DONE: if (rspReady) state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Multi-cycle load/store requester that sits between the single-cycle core's execute stage and the RAM data port.
- The RAM port stores only whole words and reads combinationally. This block gives the core byte, halfword and word loads and stores.
  - Loads: sign or zero extension.
  - Sub-word stores: read-modify-write.
  - Misaligned or out-of-range accesses are reported as faults.
- Uses a valid/ready handshake toward the core and drives the RAM address, store-enable and write-data lines directly.

Parameters:
- MEM_BYTES, 131072: size of the backing RAM in bytes; any access whose last byte is at or beyond this address faults.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- reqValid  input  1  core presents a request
- reqReady  output  1  block accepts a request this cycle
- reqAddress  input  32  byte address
- reqIsStore  input  1  1 = store, 0 = load
- reqSize  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and faults
- reqSigned  input  1  loads only: sign-extend the result
- reqWData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rspValid  output  1  response available
- rspReady  input  1  core consumes the response
- rspRData  output  32  load result after extension; 0 for stores and faults
- rspFault  output  1  request was misaligned, out of range or had an illegal size; no memory access took place
- memAddress  output  32  word-aligned byte address to the RAM (bits [1:0] always 0)
- memIsStore  output  1  RAM store enable
- memWData  output  32  RAM write word
- memRData  input  32  RAM combinational read word at memAddress

Behaviour:
- States: IDLE, READ, WRITE, DONE. Reset (asynchronous, rst_n low) forces IDLE and clears every captured register to 0.
- In reset and in IDLE, outputs are:
  - reqReady = 1 in IDLE, 0 while rst_n is low
  - rspValid = 0, rspFault = 0, rspRData = 0
  - memIsStore = 0, memAddress = 0, memWData = 0
- Accept: a request is taken on an edge where state is IDLE and reqValid = 1.
  - At that edge, address, size, signed flag, store flag and store data are captured.
  - reqReady is 1 only in IDLE.
- Fault check at accept: the request faults if any of the following holds:
  - size = 3
  - half with address[0] = 1
  - word with address[1:0] != 0
  - address + (1 << size) > MEM_BYTES (evaluated without 32-bit wrap)
- A faulting request goes IDLE to DONE with fault = 1. memIsStore is never asserted for it.
- Non-faulting transitions:
  - load: IDLE to READ to DONE
  - word store: IDLE to WRITE to DONE
  - byte or half store: IDLE to READ to WRITE to DONE
- READ:
  - memAddress = captured address with bits [1:0] cleared.
  - On the edge leaving READ, memRData is captured into an internal word register.
- Load extraction (on leaving READ), little-endian lanes:
  - byte lane = address[1:0]; half lane = address[1]
  - the selected field is right-aligned, then sign-extended if reqSigned, else zero-extended
  - word loads ignore reqSigned
- WRITE:
  - memAddress as in READ; memIsStore = 1 for exactly this one cycle.
  - memWData for a word store = captured store data.
  - For a sub-word store, memWData = captured old word with only the addressed byte/half lane replaced by the low 8/16 bits of the store data. All other bits are unchanged.
- DONE:
  - rspValid = 1; rspRData and rspFault are held stable until an edge with rspReady = 1, which returns the block to IDLE.
  - No new request can be accepted in the same cycle as response consumption. The minimum gap between accepts is therefore one cycle after consumption.
- Latency from the accept edge to rspValid high:
  - fault: 1 cycle
  - load, word store: 2 cycles
  - sub-word store: 3 cycles
- Request inputs are ignored outside IDLE.
- Reset mid-operation:
  - memIsStore drops immediately, with no partial write on the next edge.
  - A pending response is discarded.
- memIsStore, memAddress and memWData are decoded from the registered state only, with no combinational path from the req* inputs. In IDLE and DONE, memAddress = 0.

Test Plan:
- Byte load signed, addr 0x101, RAM word at 0x100 = 0x1234_80FF: rspValid 2 cycles after accept, rspRData = 0xFFFF_FF80, fault 0. Same request unsigned gives 0x0000_0080.
- Half store 0xBEEF to addr 0x202, RAM at 0x200 = 0x1122_3344: one READ cycle, then memIsStore high for exactly one cycle with memWData = 0xBEEF_3344; a subsequent word load of 0x200 returns 0xBEEF_3344.
- Word store 0xCAFE_F00D to 0x3 (misaligned): rspFault = 1 one cycle after accept, rspRData = 0, memIsStore never asserted, RAM unchanged. Also exercise addr 0x1FFFE half with MEM_BYTES=131072 (no fault) and addr 0x1FFFE word (fault).
- Backpressure: load completes while rspReady = 0 for 5 cycles; rspRData stays stable and reqReady stays 0. When rspReady rises, the next edge returns to IDLE, and the next request is accepted one cycle later.
- Reset during WRITE of a byte store: rst_n pulled low mid-cycle gives memIsStore = 0 immediately and RAM unchanged; after release, reqReady = 1 and rspValid = 0.
- Back-to-back mix, each consumed with rspReady = 1 in DONE: word store, byte store and signed half load (0x8001 to 0xFFFF_8001). This checks latencies of 2, 3 and 2 cycles and correct lane merges.
